// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the nibble-serial ALU controller.
// Holds the op encoding (also used as the ALU select), the FSM state enum
// and the ALU slice width.
package alu_seq_pkg;

  // Width of one ALU pass.
  localparam int NIB_W = 4;

  // Command op encoding; the ALU select uses the same values.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_FIX  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Add and subtract propagate carry/borrow between nibbles; logic ops do not.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs NIBBLES x 4-bit add/sub/and/or on an external combinational
// 4-bit ALU, one nibble per pass. The ALU has no carry-in, so a pending carry or
// borrow costs one extra FIX pass that adds/subtracts 1 to the held nibble.
// Optional feature: define ALU_SEQ_ZERO_EN to add the rsp_zero output.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIB_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_carry,
`ifdef ALU_SEQ_ZERO_EN
  output logic             rsp_zero,
`endif
  output logic [NIB_W-1:0] alu_a,
  output logic [NIB_W-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [NIB_W-1:0] alu_result,
  input  logic             alu_carry
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_op;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_res;
  logic [NIB_W-1:0]   r_hold;
  logic               r_c1;
  logic               r_cin;
  logic [IDX_W-1:0]   r_idx;
  logic               w_accept;
  logic               w_commit;
  logic               w_last;
  logic [NIB_W-1:0]   w_nib;
  logic               w_cin_next;
  logic [W-1:0]       w_res_next;

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_res;
  assign rsp_carry  = r_cin;
  assign w_accept   = req_valid & req_ready;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_res_next = {w_nib, r_res[W-1:NIB_W]};

  // Next-state, ALU drive and nibble-commit decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    alu_a        = '0;
    alu_b        = '0;
    alu_sel      = OP_ADD;
    w_commit     = 1'b0;
    w_nib        = alu_result;
    w_cin_next   = r_cin;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next_state = S_STEP;
      end
      S_STEP: begin
        alu_a   = r_a[NIB_W-1:0];
        alu_b   = r_b[NIB_W-1:0];
        alu_sel = r_op;
        if (is_arith(r_op) && r_cin) begin
          w_next_state = S_FIX;
        end else begin
          w_commit     = 1'b1;
          w_cin_next   = is_arith(r_op) ? alu_carry : 1'b0;
          w_next_state = w_last ? S_RESP : S_STEP;
        end
      end
      S_FIX: begin
        // Fold the incoming carry/borrow into the nibble computed in STEP.
        alu_a        = r_hold;
        alu_b        = NIB_W'(1);
        alu_sel      = r_op;
        w_commit     = 1'b1;
        w_cin_next   = r_c1 | alu_carry;
        w_next_state = w_last ? S_RESP : S_STEP;
      end
      S_RESP: begin
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Operand/result shift registers, carry chain and nibble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath is small enough to reset fully, which also gives the
    // required zero result/carry straight out of reset.
    if (!rst_n) begin
      r_op   <= OP_ADD;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_hold <= '0;
      r_c1   <= 1'b0;
      r_cin  <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_a   <= req_a;
        r_b   <= req_b;
        r_cin <= 1'b0;
        r_idx <= '0;
      end
      if (r_state == S_STEP) begin
        r_hold <= alu_result;
        r_c1   <= alu_carry;
      end
      if (w_commit) begin
        r_cin <= w_cin_next;
        r_res <= w_res_next;
        r_a   <= r_a >> NIB_W;
        r_b   <= r_b >> NIB_W;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_EN
  logic r_zero;
  assign rsp_zero = r_zero;

  // Zero flag registered alongside the final result nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_zero <= 1'b0;
    else if (w_commit && w_last) r_zero <= (w_res_next == '0);
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl with NIBBLES=4.
// Models the external combinational ALU, drives a table of commands through a
// scoreboard, then runs FIX-trace, backpressure and mid-FIX reset sequences.
// Define ALU_SEQ_ZERO_EN to also check rsp_zero.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
`ifdef ALU_SEQ_ZERO_EN
  logic         rsp_zero;
`endif
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [1:0]   alu_sel;
  logic [3:0]   alu_result;
  logic         alu_carry;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         carry;
    int           lat;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  alu_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_carry (rsp_carry),
`ifdef ALU_SEQ_ZERO_EN
    .rsp_zero  (rsp_zero),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .alu_carry (alu_carry)
  );

  always #5 clk = ~clk;

  // External 4-bit ALU: add carry-out, subtract borrow (a<b), logic ops carry 0.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a < alu_b);
      end
      OP_AND: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a command until accepted, push its expectation, then scramble inputs.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic carry);
    int t;
    exp_t e;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    e.res   = res;
    e.carry = carry;
    sb.push_back(e);
    #1;
    req_valid = 1'b0;
    req_op    = OP_OR;
    req_a     = 16'hDEAD;
    req_b     = 16'hBEEF;
  endtask

  // Count clocks from the accept edge until rsp_valid rises (bounded).
  task automatic wait_rsp(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  // Complete the response handshake and compare against the scoreboard head.
  task automatic take_rsp(input string name);
    exp_t e;
    rsp_ready = 1'b1;
    @(negedge clk);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_result"}, 32'(rsp_result), 32'(e.res));
      check({name, "_carry"}, 32'(rsp_carry), 32'(e.carry));
`ifdef ALU_SEQ_ZERO_EN
      check({name, "_zero"}, 32'(rsp_zero), 32'(e.res == '0));
`endif
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"},  32'(req_ready),  32'd1);
    check({name, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({name, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({name, "_rsp_carry"},  32'(rsp_carry),  32'd0);
    check({name, "_alu_a"},      32'(alu_a),      32'd0);
    check({name, "_alu_b"},      32'(alu_b),      32'd0);
    check({name, "_alu_sel"},    32'(alu_sel),    32'd0);
`ifdef ALU_SEQ_ZERO_EN
    check({name, "_rsp_zero"},   32'(rsp_zero),   32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_trace_a[7];
    logic [3:0] exp_trace_b[7];

    vecs[0] = '{OP_ADD, 16'h1234, 16'h4321, 16'h5555, 1'b0, 4, "add_nocarry"};
    vecs[1] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 7, "add_ripple"};
    vecs[2] = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 7, "sub_underflow"};
    vecs[3] = '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 4, "and"};
    vecs[4] = '{OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 4, "or"};
    vecs[5] = '{OP_SUB, 16'h5555, 16'h1234, 16'h4321, 1'b0, 4, "sub_noborrow"};
    vecs[6] = '{OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 4, "add_topcarry"};
    vecs[7] = '{OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 7, "sub_ripple"};

    // SUB 0x1000-0x0001 passes: STEP0 STEP1 FIX STEP2 FIX STEP3 FIX
    exp_trace_a = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
    exp_trace_b = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_ADD;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].carry);
      wait_rsp(vecs[i].name, vecs[i].lat);
      take_rsp(vecs[i].name);
    end

    // FIX passes present the held nibble against a constant 1.
    send(OP_SUB, 16'h1000, 16'h0001, 16'h0FFF, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("trace_alu_a_%0d", k), 32'(alu_a), 32'(exp_trace_a[k]));
      check($sformatf("trace_alu_b_%0d", k), 32'(alu_b), 32'(exp_trace_b[k]));
      check($sformatf("trace_alu_sel_%0d", k), 32'(alu_sel), 32'(OP_SUB));
    end
    @(posedge clk);
    #1;
    check("trace_rsp_valid_at_7", 32'(rsp_valid), 32'd1);
    take_rsp("sub_borrow_fix");

    // Backpressure: response held while a new command waits.
    send(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
    wait_rsp("bp_and", 4);
    req_op    = OP_OR;
    req_a     = 16'hF0F0;
    req_b     = 16'h3C3C;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid_%0d", k),  32'(rsp_valid),  32'd1);
      check($sformatf("bp_hold_result_%0d", k), 32'(rsp_result), 32'h3030);
      check($sformatf("bp_hold_carry_%0d", k),  32'(rsp_carry),  32'd0);
      check($sformatf("bp_req_ready_%0d", k),   32'(req_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    take_rsp("bp_and");
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{16'hFCFC, 1'b0});
    #1;
    req_valid = 1'b0;
    check("bp_taken", 32'(req_ready), 32'd0);
    wait_rsp("bp_or", 4);
    take_rsp("bp_or");

    // Reset while in FIX aborts the command immediately.
    send(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_fix_alu_b", 32'(alu_b), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    wait_rsp("post_rst", 4);
    take_rsp("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
